display_scan_ctrl: RTL
======================

# display_scan_ctrl

Time-multiplexing scan controller for the 4-digit seven-segment display. It sits between the application logic and the combinational seven-segment decoder, and drives the decoder's 2-bit digit-enable and 4-bit digit-value inputs. It cycles through the four digits at a programmable refresh rate. A new 4-digit BCD value is double-buffered so it only takes effect at a frame boundary, which prevents display tearing. Leading-zero blanking is optional.

## Interface
- REFRESH_DIV, 100000, clock cycles each digit stays lit; must be >= 2 (100 MHz clock gives 1 kHz per digit).
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  single-cycle strobe; captures value_in into the pending buffer.
- value_in  in  16  four BCD digits; [15:12] is the leftmost digit (digit 0), [3:0] is the rightmost digit (digit 3).
- blank_lz  in  1  when 1, leading zeros are blanked; sampled on every tick.
- digit_sel  out  2  registered; connects to the decoder enable (0 = leftmost anode … 3 = rightmost).
- digit_num  out  4  registered; connects to the decoder num. 4'hF means blank, which the decoder renders as all segments off.
- frame_tick  out  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.
- update_done  out  1  one-cycle pulse when the pending value has been committed to the active register.

## Operation
- Prescaler counter (cnt, width clog2(REFRESH_DIV)):
  - Counts 0 … REFRESH_DIV-1, then returns to 0.
  - Internal tick is asserted in the cycle where cnt == REFRESH_DIV-1.
- On each tick:
  - digit_sel <= digit_sel + 1, wrapping 3 -> 0 (modulo-4 arithmetic).
  - digit_num <= display value of the new digit_sel, taken from the post-commit active register.
- Buffering:
  - `load` writes value_in into `pending` and sets pend_flag.
  - A later `load` before commit overwrites `pending`. Only the last value is shown; no queueing.
- Commit (tick with digit_sel == 3, i.e. the wrap to 0):
  - If pend_flag is set: active <= pending, pend_flag cleared, update_done pulses.
  - digit 0 of the new frame already shows the new value.
- Load on the commit tick: value_in bypasses `pending` and commits directly. pend_flag ends at 0 and update_done pulses.
- Display value for digit d:
  - Nibble d of active.
  - Replaced by 4'hF when blank_lz == 1, d < 3, and nibbles 0 … d of active are all zero.
  - Digit 3 is never blanked, so 0000 displays as "   0".
- Non-BCD nibbles (A–F) pass through unmodified; the decoder blanks them. For leading-zero blanking, only the value 0 counts as a zero.
- No state machine beyond the 2-bit scan position; scan states are D0 -> D1 -> D2 -> D3 -> D0, unconditional, advanced by tick.

## Timing
- Reset values:
  - cnt = 0, digit_sel = 0, digit_num = 4'hF.
  - active = 16'h0000, pending = 16'h0000, pend_flag = 0.
  - frame_tick = 0, update_done = 0.
- Reset is asynchronous: outputs take their reset values immediately on rst_n falling, independent of clk.
- Reset asserted mid-frame or mid-pending discards the pending value; no update_done is produced.
- First tick occurs REFRESH_DIV cycles after rst_n deasserts (the clock edge after cnt == REFRESH_DIV-1).
- digit_sel and digit_num change on the same edge, so the decoder never sees a mismatched pair.
- frame_tick and update_done are registered. They are high for exactly the one cycle after the commit edge, together with digit_sel == 0.
- Load-to-display latency:
  - Minimum 1 cycle (load on the commit tick).
  - Maximum 4*REFRESH_DIV cycles.
- Frame period is exactly 4*REFRESH_DIV cycles, unaffected by load or blank_lz.

## Test plan
All scenarios use REFRESH_DIV = 4.
- Reset, then release rst_n:
  - Cycles 1–3: digit_sel = 0, digit_num = F.
  - Edge 4: digit_sel = 1, digit_num = 0.
  - Wrap to 0 at edge 16; frame_tick pulses once per 16 cycles.
- Load 16'h1234 mid-frame (digit_sel = 1):
  - Display stays on 0000 until the wrap.
  - update_done pulses with digit_sel = 0.
  - Next frame shows digit_num 1, 2, 3, 4 on sel 0–3.
- Load 16'h1111 then 16'h5678 in the same frame: only 5678 appears, and update_done pulses once.
- Load 16'h9999 on the commit tick (cnt = 3, sel = 3): the same edge shows sel = 0, num = 9; update_done = 1; no extra commit at the next wrap.
- blank_lz = 1 with active 16'h0040: sel 0–3 shows F, F, 4, 0. With 16'h0000: F, F, F, 0. With blank_lz = 0 on 0040: 0, 0, 4, 0.
- Load 16'h4321, then assert rst_n = 0 for 2 cycles before the wrap:
  - Outputs drop asynchronously to sel = 0, num = F.
  - After release, the display shows 0000 and update_done never pulses.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Time-multiplexing scan controller for a 4-digit seven-segment display.
//   It steps through the four digits at a programmable refresh rate and
//   drives the enable and value inputs of a combinational seven-segment
//   decoder. A new 4-digit BCD value is double-buffered and only takes
//   effect at a frame boundary, so the display never tears. Leading-zero
//   blanking is optional.
//
// Parameters
//   REFRESH_DIV  clock cycles each digit stays lit (>= 2)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   load         single-cycle strobe, captures value_in
//   value_in     four BCD digits, [15:12] = leftmost (digit 0)
//   blank_lz     1 = blank leading zeros (digit 3 is never blanked)
//   digit_sel    registered digit enable, 0 = leftmost .. 3 = rightmost
//   digit_num    registered digit value, 4'hF = blank
//   frame_tick   one-cycle pulse after the scan wraps from digit 3 to 0
//   update_done  one-cycle pulse after a pending value is committed
module display_scan_ctrl #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value_in,
  input  logic        blank_lz,
  output logic [1:0]  digit_sel,
  output logic [3:0]  digit_num,
  output logic        frame_tick,
  output logic        update_done
);

  localparam int              CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [15:0]      active;
  logic [15:0]      pending;
  logic             pend_flag;

  logic             tick;
  logic             commit;
  logic             commit_new;
  logic [1:0]       sel_next;
  logic [15:0]      active_next;

  // Value shown for digit d of val. A digit is blanked when it and every
  // digit to its left are zero; only the value 0 counts as zero, so A-F
  // pass through and the rightmost digit always shows.
  function automatic logic [3:0] disp_nibble(input logic [15:0] val,
                                             input logic [1:0]  d,
                                             input logic        blz);
    logic [3:0] nib;
    logic       lead_zero;
    case (d)
      2'd0: begin nib = val[15:12]; lead_zero = (val[15:12] == 4'h0); end
      2'd1: begin nib = val[11:8];  lead_zero = (val[15:8]  == 8'h00); end
      2'd2: begin nib = val[7:4];   lead_zero = (val[15:4]  == 12'h000); end
      default: begin nib = val[3:0]; lead_zero = 1'b0; end
    endcase
    return (blz && lead_zero) ? 4'hF : nib;
  endfunction

  // A load in the commit cycle bypasses the pending buffer so the new
  // value is visible on digit 0 of the very next frame.
  always_comb begin
    tick        = (cnt == CNT_MAX);
    commit      = tick && (digit_sel == 2'd3);
    commit_new  = commit && (load || pend_flag);
    sel_next    = digit_sel + 2'd1;
    active_next = active;
    if (commit) begin
      if (load)           active_next = value_in;
      else if (pend_flag) active_next = pending;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      digit_sel   <= 2'd0;
      digit_num   <= 4'hF;
      active      <= 16'h0000;
      pending     <= 16'h0000;
      pend_flag   <= 1'b0;
      frame_tick  <= 1'b0;
      update_done <= 1'b0;
    end else begin
      cnt         <= tick ? '0 : cnt + 1'b1;
      frame_tick  <= commit;
      update_done <= commit_new;
      active      <= active_next;

      if (commit) begin
        pend_flag <= 1'b0;
      end else if (load) begin
        pending   <= value_in;
        pend_flag <= 1'b1;
      end

      // digit_sel and digit_num move together so the decoder never sees
      // a mismatched pair.
      if (tick) begin
        digit_sel <= sel_next;
        digit_num <= disp_nibble(active_next, sel_next, blank_lz);
      end
    end
  end

endmodule
